// File: rtl/cache_backing_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_backing_mem_pkg
// Description : Constants shared by the backing-memory responder and the
//               cache controller: FSM state encodings, rw encoding, and the
//               latency-counter load helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cache_backing_mem_pkg;

   // Responder FSM state encodings (also decoded by the cache controller)
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;

   // Request direction encoding, identical to the cache rw input
   localparam logic c_RW_WRITE = 1'b1;
   localparam logic c_RW_READ  = 1'b0;

   // Latency counter width; covers the legal LATENCY range 1..15
   localparam int c_LAT_W = 4;

   // Value loaded into the down-counter at accept. The counter expires
   // (reaches zero) on the cycle whose closing edge commits the access.
   function automatic logic [c_LAT_W-1:0] lat_load(input int latency);
      return c_LAT_W'(latency - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_backing_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_backing_mem_array
// Description : Single-port word array (mem_array) with synchronous write
//               and asynchronous read, plus four fixed debug taps on
//               words 0..3. Power-up contents selected by INIT_MODE:
//               0 = all zero, 1 = word i holds i. Contents have no reset.
// Ports       : clk      - clock, rising edge
//               i_we     - write enable
//               i_addr   - word address (read and write)
//               i_wdata  - write data
//               o_rdata  - combinational read of word i_addr
//               o_tap0-3 - combinational reads of words 0..3
// Revision    : 1.0 - initial release
// ============================================================================
module cache_backing_mem_array #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int INIT_MODE = 1
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic [DATA_W-1:0] o_tap0,
   output logic [DATA_W-1:0] o_tap1,
   output logic [DATA_W-1:0] o_tap2,
   output logic [DATA_W-1:0] o_tap3
);

   localparam int c_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] w_words [c_DEPTH];

   // One register per word so each can carry its own power-up value
   // without any reset path touching the array.
   for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] r_word = (INIT_MODE == 1) ? DATA_W'(gi) : '0;

      always_ff @(posedge clk) begin
         if (i_we && (i_addr == ADDR_W'(gi))) begin
            r_word <= i_wdata;
         end
      end

      assign w_words[gi] = r_word;
   end

   assign o_rdata = w_words[i_addr];
   assign o_tap0  = w_words[0];
   assign o_tap1  = w_words[1];
   assign o_tap2  = w_words[2];
   assign o_tap3  = w_words[3];

endmodule
`default_nettype wire

// File: rtl/cache_backing_mem.sv
`default_nettype none
// ============================================================================
// Module      : cache_backing_mem
// Description : Main-memory responder behind the cache miss/write-through
//               port. Accepts one word request at a time, commits it after
//               LATENCY cycles and holds the response until acknowledged.
// Ports       : clk, clr               - clock / synchronous active-high reset
//               req_valid/ready/rw     - request handshake and direction
//               req_addr, req_wdata    - request address and write data
//               resp_valid/rw/rdata    - response, held until resp_ack
//               resp_ack               - cache consumes the response
//               rd_cnt, wr_cnt         - completed reads / writes, mod 256
//               ram0..ram3             - live contents of words 0..3
// Revision    : 1.0 - initial release
// ============================================================================
module cache_backing_mem
   import cache_backing_mem_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int LATENCY   = 3,
   parameter int INIT_MODE = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_rw,
   output logic [DATA_W-1:0] resp_rdata,
   input  logic              resp_ack,
   output logic [7:0]        rd_cnt,
   output logic [7:0]        wr_cnt,
   output logic [DATA_W-1:0] ram0,
   output logic [DATA_W-1:0] ram1,
   output logic [DATA_W-1:0] ram2,
   output logic [DATA_W-1:0] ram3
);

   logic [1:0]         r_state;
   logic [c_LAT_W-1:0] r_lat_cnt;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_rw;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_resp_valid;
   logic               r_resp_rw;
   logic [DATA_W-1:0]  r_resp_rdata;
   logic [7:0]         r_rd_cnt;
   logic [7:0]         r_wr_cnt;

   logic               w_accept;
   logic               w_commit;
   logic               w_mem_we;
   logic [DATA_W-1:0]  w_mem_rdata;

   assign w_accept = (r_state == c_IDLE) && req_valid;
   assign w_commit = (r_state == c_WAIT) && (r_lat_cnt == '0);
   // A reset in the commit cycle aborts the access, so the array write
   // must be gated as well as the FSM.
   assign w_mem_we = w_commit && (r_rw == c_RW_WRITE) && !clr;

   // Request latches: no reset needed, only meaningful after an accept.
   always_ff @(posedge clk) begin
      if (w_accept && !clr) begin
         r_addr  <= req_addr;
         r_rw    <= req_rw;
         r_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state      <= c_IDLE;
         r_lat_cnt    <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rw    <= 1'b0;
         r_resp_rdata <= '0;
         r_rd_cnt     <= 8'd0;
         r_wr_cnt     <= 8'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (req_valid) begin
                  r_lat_cnt <= lat_load(LATENCY);
                  r_state   <= c_WAIT;
               end
            end
            c_WAIT: begin
               if (r_lat_cnt == '0) begin
                  // Commit edge: the read samples the array before any
                  // write landing on this same edge.
                  r_state      <= c_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_rw    <= r_rw;
                  if (r_rw == c_RW_WRITE) begin
                     r_resp_rdata <= '0;
                     r_wr_cnt     <= r_wr_cnt + 8'd1;
                  end else begin
                     r_resp_rdata <= w_mem_rdata;
                     r_rd_cnt     <= r_rd_cnt + 8'd1;
                  end
               end else begin
                  r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
               end
            end
            c_RESP: begin
               if (resp_ack) begin
                  r_state      <= c_IDLE;
                  r_resp_valid <= 1'b0;
                  r_resp_rw    <= 1'b0;
                  r_resp_rdata <= '0;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   cache_backing_mem_array #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .INIT_MODE (INIT_MODE)
   ) u_mem_array (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rdata),
      .o_tap0  (ram0),
      .o_tap1  (ram1),
      .o_tap2  (ram2),
      .o_tap3  (ram3)
   );

   assign req_ready  = (r_state == c_IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_rw    = r_resp_rw;
   assign resp_rdata = r_resp_rdata;
   assign rd_cnt     = r_rd_cnt;
   assign wr_cnt     = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_backing_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_backing_mem
// Description : Scoreboard bench for cache_backing_mem. Main instance uses
//               LATENCY=3, INIT_MODE=1; a second instance uses LATENCY=1,
//               INIT_MODE=0. Expected responses are queued at issue time
//               and popped by a monitor at each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_backing_mem;

   localparam int c_LAT = 3;

   logic       clk = 1'b0;
   logic       clr = 1'b1;

   logic       req_valid = 1'b0, req_rw = 1'b0, resp_ack = 1'b0;
   logic [7:0] req_addr = '0, req_wdata = '0;
   logic       req_ready, resp_valid, resp_rw;
   logic [7:0] resp_rdata, rd_cnt, wr_cnt, ram0, ram1, ram2, ram3;

   logic       req_valid_1 = 1'b0, req_rw_1 = 1'b0, resp_ack_1 = 1'b0;
   logic [7:0] req_addr_1 = '0, req_wdata_1 = '0;
   logic       req_ready_1, resp_valid_1, resp_rw_1;
   logic [7:0] resp_rdata_1, rd_cnt_1, wr_cnt_1;
   logic [7:0] ram0_1, ram1_1, ram2_1, ram3_1;

   int test_cnt = 0;
   int fail_cnt = 0;

   logic [8:0] exp_q [$];
   logic [7:0] model [256];

   always #5 clk = ~clk;

   cache_backing_mem #(.ADDR_W(8), .DATA_W(8), .LATENCY(c_LAT), .INIT_MODE(1)) u_dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rw(resp_rw), .resp_rdata(resp_rdata),
      .resp_ack(resp_ack), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
      .ram0(ram0), .ram1(ram1), .ram2(ram2), .ram3(ram3)
   );

   cache_backing_mem #(.ADDR_W(8), .DATA_W(8), .LATENCY(1), .INIT_MODE(0)) u_dut1 (
      .clk(clk), .clr(clr),
      .req_valid(req_valid_1), .req_ready(req_ready_1), .req_rw(req_rw_1),
      .req_addr(req_addr_1), .req_wdata(req_wdata_1),
      .resp_valid(resp_valid_1), .resp_rw(resp_rw_1), .resp_rdata(resp_rdata_1),
      .resp_ack(resp_ack_1), .rd_cnt(rd_cnt_1), .wr_cnt(wr_cnt_1),
      .ram0(ram0_1), .ram1(ram1_1), .ram2(ram2_1), .ram3(ram3_1)
   );

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      test_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   // Monitor: one pop per response, on the cycle whose closing edge sees the ack.
   always @(negedge clk) begin
      if (!clr && resp_valid && resp_ack) begin
         if (exp_q.size() == 0) begin
            test_cnt++;
            fail_cnt++;
            $display("FAIL scoreboard: unexpected response rw=%0b rdata=%0h", resp_rw, resp_rdata);
         end else begin
            check("scoreboard", {23'd0, resp_rw, resp_rdata}, {23'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   // Full handshake on the main DUT: wait ready, accept, measure latency,
   // hold the response 'hold' cycles unacked, then ack.
   task automatic issue(input logic rw, input logic [7:0] addr, input logic [7:0] wd,
                        input int hold, input string nm);
      int n;
      logic [7:0] exp;
      exp = rw ? 8'h00 : model[addr];
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      check({nm, " ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
      exp_q.push_back({rw, exp});
      tick();                       // accept edge E0
      req_valid = 1'b0;
      if (rw) model[addr] = wd;
      n = 0;
      while (!resp_valid && n < 40) begin tick(); n++; end
      check({nm, " latency"}, n, c_LAT);
      for (int h = 0; h < hold; h++) begin
         check({nm, " held"}, {22'd0, resp_valid, resp_rw, resp_rdata}, {22'd0, 1'b1, rw, exp});
         tick();
      end
      resp_ack = 1'b1;
      tick();
      resp_ack = 1'b0;
      check({nm, " post-ack"}, {23'd0, resp_valid, req_ready, resp_rdata}, {23'd0, 1'b0, 1'b1, 8'h00});
   endtask

   initial begin
      int  n;
      bit  seen;
      for (int i = 0; i < 256; i++) model[i] = 8'(i);

      // 1. Reset state
      tick(); tick();
      clr = 1'b0;
      check("t1 req_ready", {31'd0, req_ready}, 32'd1);
      check("t1 resp_valid", {31'd0, resp_valid}, 32'd0);
      check("t1 counters", {16'd0, rd_cnt, wr_cnt}, 32'd0);
      check("t1 ram0..3", {ram0, ram1, ram2, ram3}, 32'h00010203);

      // 2. Read 0x0F, response held for 4 unacked cycles
      issue(1'b0, 8'h0F, 8'h00, 4, "t2 read");
      check("t2 rd_cnt", {24'd0, rd_cnt}, 32'd1);

      // 3. Write 0xAF to 0x01 then read it back
      pulse_clr();
      issue(1'b1, 8'h01, 8'hAF, 1, "t3 write");
      check("t3 ram1", {24'd0, ram1}, 32'h0000_00AF);
      issue(1'b0, 8'h01, 8'h00, 2, "t3 read");
      check("t3 counts", {16'd0, wr_cnt, rd_cnt}, 32'h0000_0101);

      // 4. req_valid held high, ack tied high: one accept per LATENCY+2 cycles
      pulse_clr();
      resp_ack  = 1'b1;
      req_valid = 1'b1;
      req_rw    = 1'b0;
      for (int k = 0; k < 20; k++) begin
         req_addr = 8'(16 + k);
         exp_q.push_back({1'b0, model[16 + k]});
         n = 0;
         while (!req_ready && n < 20) begin tick(); n++; end
         if (k > 0) check("t4 period", n + 1, c_LAT + 2);
         tick();
      end
      req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
      tick();
      resp_ack = 1'b0;
      check("t4 queue drained", exp_q.size(), 32'd0);
      check("t4 rd_cnt", {24'd0, rd_cnt}, 32'd20);

      // 5. Reset during WAIT aborts a write; reset on the request edge wins
      pulse_clr();
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h02; req_wdata = 8'hC0;
      tick();                       // accepted at E0
      req_valid = 1'b0;
      clr = 1'b1;
      tick();                       // reset at E1
      clr = 1'b0;
      check("t5 ready after clr", {31'd0, req_ready}, 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (resp_valid) seen = 1'b1;
         tick();
      end
      check("t5 no response", {31'd0, seen}, 32'd0);
      check("t5 ram2", {24'd0, ram2}, {24'd0, model[2]});
      check("t5 wr_cnt", {24'd0, wr_cnt}, 32'd0);
      req_valid = 1'b1; clr = 1'b1;
      tick();
      req_valid = 1'b0; clr = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (resp_valid || !req_ready) seen = 1'b1;
         tick();
      end
      check("t5 clr beats request", {31'd0, seen}, 32'd0);
      check("t5 ram2 again", {24'd0, ram2}, {24'd0, model[2]});

      // 6. 256 writes wrap wr_cnt
      pulse_clr();
      for (int k = 0; k < 256; k++) begin
         issue(1'b1, 8'(k), ~8'(k), 0, "t6 write");
         if (k == 254) check("t6 wr_cnt 255", {24'd0, wr_cnt}, 32'd255);
      end
      check("t6 wr_cnt wrap", {24'd0, wr_cnt}, 32'd0);
      check("t6 ram0..3", {ram0, ram1, ram2, ram3}, 32'hFFFEFDFC);
      issue(1'b0, 8'h80, 8'h00, 0, "t6 read");
      check("t6 rd_cnt", {24'd0, rd_cnt}, 32'd1);

      // 6b. LATENCY=1, INIT_MODE=0 instance
      pulse_clr();
      check("t6b ram0..3 zero", {ram0_1, ram1_1, ram2_1, ram3_1}, 32'd0);
      req_valid_1 = 1'b1; req_rw_1 = 1'b0; req_addr_1 = 8'h05;
      tick();                       // E0
      req_valid_1 = 1'b0;
      check("t6b valid after E0", {31'd0, resp_valid_1}, 32'd0);
      tick();                       // E1
      check("t6b read resp at E1", {22'd0, resp_valid_1, resp_rw_1, resp_rdata_1}, {22'd0, 1'b1, 1'b0, 8'h00});
      resp_ack_1 = 1'b1;
      tick();
      resp_ack_1 = 1'b0;
      check("t6b rd_cnt", {24'd0, rd_cnt_1}, 32'd1);
      req_valid_1 = 1'b1; req_rw_1 = 1'b1; req_addr_1 = 8'h03; req_wdata_1 = 8'h5A;
      tick();
      req_valid_1 = 1'b0;
      tick();
      check("t6b write resp", {22'd0, resp_valid_1, resp_rw_1, resp_rdata_1}, {22'd0, 1'b1, 1'b1, 8'h00});
      check("t6b ram3", {24'd0, ram3_1}, 32'h0000_005A);
      resp_ack_1 = 1'b1;
      tick();
      resp_ack_1 = 1'b0;
      check("t6b wr_cnt", {24'd0, wr_cnt_1}, 32'd1);

      check("final queue empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
`default_nettype wire
